capture_seq_ctrl: RTL and testbench

//  Sequencer and port arbiter for the dual-bank capture block RAMs (bank A, bank B; two write ports each).

---
 rtl/capture_seq_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_capture_seq_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_seq_ctrl.sv
// capture_seq_ctrl: capture sequencer and write/read-back port arbiter for the dual-bank capture RAMs.
// Optional build macro CAP_TRIG_EN: ARMED waits for a registered rising edge of trig before capturing.
module capture_seq_ctrl #(
  parameter int AW         = 19,
  parameter int DW         = 16,
  parameter int HALF_DEPTH = 176128,
  parameter int CAP_LEN    = 176128,
  parameter int DECIM      = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic          trig,
  input  logic          mcu_ack,
  input  logic          smp_valid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addra,
  output logic [AW-1:0] mem_addrb,
  input  logic [DW-1:0] mem_douta_a,
  input  logic [DW-1:0] mem_douta_b,
  input  logic          mcu_rd_en,
  input  logic [AW-1:0] mcu_rd_addr,
  input  logic          mcu_bank,
  output logic [DW-1:0] mcu_rd_data,
  output logic          mcu_rd_valid,
  output logic          mcu_rd_err,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] wr_count,
  output logic [1:0]    state_dbg
);

  localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW1 = AW + 1;
  localparam logic [DCW-1:0] DECIM_LAST = DCW'(DECIM - 1);
  localparam logic [AW-1:0]  LAST_PTR   = AW'(CAP_LEN - 1);
  localparam logic [AW-1:0]  HALF_OFS   = AW'(HALF_DEPTH);
  localparam logic [AW:0]    RD_LIMIT   = AW1'(2 * HALF_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  wr_count_q;
  logic [DCW-1:0] decim_cnt;
  logic           wr_fire;
  logic           last_write;
  logic           rd_in_range;
  logic           rd_ok;
  logic           rd_err;
  logic           rd_ok_q;
  logic           rd_err_q;
  logic           bank_q;
  logic           trig_go;

`ifdef CAP_TRIG_EN
  logic trig_q, trig_qq;

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q  <= 1'b0;
      trig_qq <= 1'b0;
    end else begin
      trig_q  <= trig;
      trig_qq <= trig_q;
    end
  end

  // A level already high before ARMED never produces an edge here.
  assign trig_go = trig_q && !trig_qq;
`else
  logic unused_trig;
  assign unused_trig = trig;
  assign trig_go     = 1'b1;
`endif

  // arm takes priority over any write in the same cycle: the restart drops it.
  assign wr_fire     = (state == CAPTURE) && smp_valid && (decim_cnt == '0) && !arm;
  assign last_write  = wr_fire && (wr_ptr == LAST_PTR);
  assign rd_in_range = ({1'b0, mcu_rd_addr} < RD_LIMIT);

  // MCU read handshake: mcu_rd_en is a single-cycle request with no back-pressure;
  // every request yields exactly one pulse two cycles later, mcu_rd_valid (with
  // mcu_rd_data) if accepted or mcu_rd_err if refused.
  assign rd_ok  = mcu_rd_en && (state == DONE) && rd_in_range;
  assign rd_err = mcu_rd_en && !rd_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (arm) state_nxt = ARMED;
      end
      ARMED: begin
        if (arm)          state_nxt = ARMED;
        else if (trig_go) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (arm)             state_nxt = ARMED;
        else if (last_write) state_nxt = DONE;
      end
      DONE: begin
        if (arm)          state_nxt = ARMED;
        else if (mcu_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Every arm lands in ARMED, so arm alone clears the capture counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      wr_count_q <= '0;
      decim_cnt  <= '0;
    end else if (arm) begin
      wr_ptr     <= '0;
      wr_count_q <= '0;
      decim_cnt  <= '0;
    end else if ((state == CAPTURE) && smp_valid) begin
      decim_cnt <= (decim_cnt == DECIM_LAST) ? '0 : decim_cnt + DCW'(1);
      if (wr_fire) begin
        wr_ptr     <= wr_ptr + AW'(1);
        wr_count_q <= wr_count_q + AW'(1);
      end
    end
  end

  // Writes and reads are exclusive by state; reset blocks any RAM access at once.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addra = mcu_rd_addr;
    mem_addrb = '0;
    if (reset) begin
      mem_addra = '0;
    end else if (wr_fire) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addra = wr_ptr;
      mem_addrb = wr_ptr + HALF_OFS;
    end else if (rd_ok) begin
      mem_en = 1'b1;
    end
  end

  // Stage 1 tracks the RAM's one-cycle latency; stage 2 registers the bank-selected data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ok_q      <= 1'b0;
      rd_err_q     <= 1'b0;
      bank_q       <= 1'b0;
      mcu_rd_valid <= 1'b0;
      mcu_rd_err   <= 1'b0;
      mcu_rd_data  <= '0;
    end else begin
      rd_ok_q      <= rd_ok;
      rd_err_q     <= rd_err;
      bank_q       <= mcu_bank;
      mcu_rd_valid <= rd_ok_q;
      mcu_rd_err   <= rd_err_q;
      if (rd_ok_q) begin
        mcu_rd_data <= bank_q ? mem_douta_b : mem_douta_a;
      end else begin
        mcu_rd_data <= '0;
      end
    end
  end

  assign busy      = (state == ARMED) || (state == CAPTURE);
  assign done      = (state == DONE);
  assign wr_count  = wr_count_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_capture_seq_ctrl.sv
// tb_capture_seq_ctrl: self-checking bench for capture_seq_ctrl with a small RAM model.
// Build with CAP_TRIG_EN defined to also exercise the trigger-gated start.
module tb_capture_seq_ctrl;

  localparam int AW   = 6;
  localparam int DW   = 16;
  localparam int HALF = 16;
  localparam int CAPL = 8;
  localparam int DEC  = 2;
`ifdef CAP_TRIG_EN
  localparam int TRIG_LAT = 1;
`else
  localparam int TRIG_LAT = 0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_CAPT = 2'd2, S_DONE = 2'd3;

  logic          clk, reset, arm, trig, mcu_ack, smp_valid;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addra, mem_addrb;
  logic [DW-1:0] mem_douta_a, mem_douta_b;
  logic          mcu_rd_en, mcu_bank;
  logic [AW-1:0] mcu_rd_addr;
  logic [DW-1:0] mcu_rd_data;
  logic          mcu_rd_valid, mcu_rd_err, busy, done;
  logic [AW-1:0] wr_count;
  logic [1:0]    state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] wexp, rexp;

  typedef struct {
    logic [AW-1:0] addr;
    logic          bank;
    logic          exp_err;
    logic [DW-1:0] exp_data;
  } rd_vec_t;

  rd_vec_t rd_tbl[7];

  capture_seq_ctrl #(
    .AW(AW), .DW(DW), .HALF_DEPTH(HALF), .CAP_LEN(CAPL), .DECIM(DEC)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .trig(trig), .mcu_ack(mcu_ack),
    .smp_valid(smp_valid), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addra(mem_addra), .mem_addrb(mem_addrb),
    .mem_douta_a(mem_douta_a), .mem_douta_b(mem_douta_b),
    .mcu_rd_en(mcu_rd_en), .mcu_rd_addr(mcu_rd_addr), .mcu_bank(mcu_bank),
    .mcu_rd_data(mcu_rd_data), .mcu_rd_valid(mcu_rd_valid), .mcu_rd_err(mcu_rd_err),
    .busy(busy), .done(done), .wr_count(wr_count), .state_dbg(state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required run to finish");
    $fatal(1, "bench timed out");
  end

  // RAM model: 1-cycle read latency, bank-distinguishable contents.
  always @(posedge clk) begin
    if (mem_en === 1'b1 && mem_we === 1'b0) begin
      mem_douta_a <= 16'hA000 | 16'(mem_addra);
      mem_douta_b <= 16'hB000 | 16'(mem_addra);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_writes(input int first, input int n);
    for (int i = first; i < first + n; i++)
      exp_wr_q.push_back(32'((i << AW) | (i + HALF)));
  endtask

  task automatic push_rd(input logic err, input logic [DW-1:0] data);
    exp_rd_q.push_back({14'd0, err, !err, err ? 16'h0000 : data});
  endtask

  task automatic trig_pulse();
`ifdef CAP_TRIG_EN
    trig = 1'b1;
    tick();
    trig = 1'b0;
`endif
  endtask

  task automatic wait_writes_drained(input string name);
    int cyc;
    cyc = 0;
    while (exp_wr_q.size() != 0 && cyc < 60) begin
      tick();
      cyc++;
    end
    check(name, exp_wr_q.size(), 0);
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
    check(name, done, 1);
  endtask

  // Scoreboard: writes and read results are compared in the order they were expected.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addra=%0d addrb=%0d, required no write", mem_addra, mem_addrb);
      end else begin
        wexp = exp_wr_q.pop_front();
        check("write_addr", {20'd0, mem_addra, mem_addrb}, wexp);
      end
      check("we_only_in_capture", state_dbg, S_CAPT);
    end
    if (mcu_rd_valid === 1'b1 || mcu_rd_err === 1'b1) begin
      if (exp_rd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_read_result: err=%0b valid=%0b data=%0h, required none", mcu_rd_err, mcu_rd_valid, mcu_rd_data);
      end else begin
        rexp = exp_rd_q.pop_front();
        check("read_result", {14'd0, mcu_rd_err, mcu_rd_valid, mcu_rd_data}, rexp);
      end
    end
  end

  initial begin
    int cyc;
    rd_tbl[0] = '{addr: 6'd5,  bank: 1'b1, exp_err: 1'b0, exp_data: 16'hB005};
    rd_tbl[1] = '{addr: 6'd5,  bank: 1'b0, exp_err: 1'b0, exp_data: 16'hA005};
    rd_tbl[2] = '{addr: 6'd31, bank: 1'b0, exp_err: 1'b0, exp_data: 16'hA01F};
    rd_tbl[3] = '{addr: 6'd32, bank: 1'b0, exp_err: 1'b1, exp_data: 16'h0000};
    rd_tbl[4] = '{addr: 6'd0,  bank: 1'b1, exp_err: 1'b0, exp_data: 16'hB000};
    rd_tbl[5] = '{addr: 6'd63, bank: 1'b1, exp_err: 1'b1, exp_data: 16'h0000};
    rd_tbl[6] = '{addr: 6'd20, bank: 1'b0, exp_err: 1'b0, exp_data: 16'hA014};

    reset = 1'b1; arm = 1'b0; trig = 1'b0; mcu_ack = 1'b0; smp_valid = 1'b0;
    mcu_rd_en = 1'b0; mcu_rd_addr = '0; mcu_bank = 1'b0;
    mem_douta_a = '0; mem_douta_b = '0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("rst_state", state_dbg, S_IDLE);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_addrb", mem_addrb, 0);
    check("rst_rd_valid", mcu_rd_valid, 0);
    check("rst_rd_err", mcu_rd_err, 0);
    check("rst_rd_data", mcu_rd_data, 0);

    // Full capture with two refused MCU requests mid-capture.
    push_writes(0, CAPL);
    smp_valid = 1'b1;
    arm = 1'b1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
      arm = 1'b0;
      mcu_rd_en = 1'b0;
`ifdef CAP_TRIG_EN
      trig = (cyc == 1);
`endif
      if (cyc == 1) begin
        #1;
        check("armed_busy", busy, 1);
      end
      if (cyc == 5 + TRIG_LAT) begin
        mcu_rd_en = 1'b1; mcu_rd_addr = 6'd3;
        push_rd(1'b1, 16'h0);
        #1;
        check("refused_no_ram", mem_en, 0);
      end
      if (cyc == 6 + TRIG_LAT) begin
        mcu_rd_en = 1'b1; mcu_rd_addr = 6'd9;
        push_rd(1'b1, 16'h0);
      end
    end
    mcu_rd_en = 1'b0;
    check("done_latency", cyc, 17 + TRIG_LAT);
    check("cap_wr_count", wr_count, CAPL);
    check("cap_writes_all_seen", exp_wr_q.size(), 0);
    check("cap_busy_low", busy, 0);
    check("cap_refusals_seen", exp_rd_q.size(), 0);

    // Single read-back with explicit latency.
    mcu_rd_en = 1'b1; mcu_rd_addr = 6'd5; mcu_bank = 1'b1;
    push_rd(1'b0, 16'hB005);
    #1;
    check("rd_addra", mem_addra, 5);
    check("rd_mem_en", mem_en, 1);
    check("rd_mem_we", mem_we, 0);
    tick();
    mcu_rd_en = 1'b0;
    check("rd_valid_not_yet", mcu_rd_valid, 0);
    tick();
    check("rd_valid_lat2", mcu_rd_valid, 1);
    check("rd_data_lat2", mcu_rd_data, 16'hB005);

    // Table-driven back-to-back reads.
    for (int i = 0; i < 7; i++) begin
      mcu_rd_en = 1'b1; mcu_rd_addr = rd_tbl[i].addr; mcu_bank = rd_tbl[i].bank;
      push_rd(rd_tbl[i].exp_err, rd_tbl[i].exp_data);
      #1;
      check("tbl_mem_en", mem_en, {31'd0, !rd_tbl[i].exp_err});
      check("tbl_mem_we", mem_we, 0);
      tick();
    end
    mcu_rd_en = 1'b0; mcu_bank = 1'b0; mcu_rd_addr = '0;
    repeat (3) tick();
    check("tbl_results_drained", exp_rd_q.size(), 0);

    // arm + mcu_ack together, then restart after three writes.
    arm = 1'b1; mcu_ack = 1'b1;
    push_writes(0, 3);
    tick();
    arm = 1'b0; mcu_ack = 1'b0;
    #1;
    check("arm_wins_state", state_dbg, S_ARMED);
    check("arm_clears_count", wr_count, 0);
    trig_pulse();
    wait_writes_drained("restart_three_writes");
    check("restart_count3", wr_count, 3);
    tick();
    arm = 1'b1;
    #1;
    check("arm_drops_write", mem_we, 0);
    tick();
    arm = 1'b0;
    check("restart_state", state_dbg, S_ARMED);
    push_writes(0, CAPL);
    trig_pulse();
    wait_done("restart_done");
    check("restart_wr_count", wr_count, CAPL);
    mcu_ack = 1'b1;
    tick();
    mcu_ack = 1'b0;
    #1;
    check("ack_idle", state_dbg, S_IDLE);
    check("ack_keeps_count", wr_count, CAPL);

    // Reset at the fourth write.
    arm = 1'b1;
    push_writes(0, 3);
    tick();
    arm = 1'b0;
    trig_pulse();
    wait_writes_drained("pre_reset_writes");
    tick();
    reset = 1'b1;
    #1;
    check("reset_blocks_write", mem_we, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_state", state_dbg, S_IDLE);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr_count", wr_count, 0);
    check("mid_rst_mem_en", mem_en, 0);
    repeat (10) tick();
    check("post_rst_still_idle", state_dbg, S_IDLE);

`ifdef CAP_TRIG_EN
    // Held trigger level must not start a capture; a fresh edge must.
    trig = 1'b1;
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (8) tick();
    check("trig_level_stays_armed", state_dbg, S_ARMED);
    trig = 1'b0;
    tick();
    push_writes(0, CAPL);
    trig = 1'b1;
    cyc = 0;
    while (mem_we !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("trig_first_write_in_time", (cyc <= DEC + 2) ? 1 : 0, 1);
    trig = 1'b0;
    wait_done("trig_done");
`endif

    smp_valid = 1'b0;
    repeat (3) tick();
    check("final_wr_q_empty", exp_wr_q.size(), 0);
    check("final_rd_q_empty", exp_rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
